// File: rtl/minterm_lut_sweep_if.sv
// Bus interface for minterm_lut_sweep: mask writes, single evaluations and
// sweep result stream. The don't-care signals exist only when
// MINTERM_LUT_DC_EN is defined.
interface minterm_lut_sweep_if #(
  parameter int N = 4
);
  logic         cfg_we;
  logic [N-1:0] cfg_addr;
  logic         cfg_data;
  logic         in_valid;
  logic [N-1:0] in_x;
  logic         out_valid;
  logic         out_y;
  logic         sweep_start;
  logic         busy;
  logic         sweep_valid;
  logic [N-1:0] sweep_x;
  logic         sweep_y;
  logic         done;
  logic [N:0]   ones_count;
`ifdef MINTERM_LUT_DC_EN
  logic         cfg_dc;
  logic         sweep_dc;
  logic [N:0]   dc_count;
`endif

  modport master (
`ifdef MINTERM_LUT_DC_EN
    output cfg_dc,
    input  sweep_dc, dc_count,
`endif
    output cfg_we, cfg_addr, cfg_data, in_valid, in_x, sweep_start,
    input  out_valid, out_y, busy, sweep_valid, sweep_x, sweep_y, done,
           ones_count
  );

  modport slave (
`ifdef MINTERM_LUT_DC_EN
    input  cfg_dc,
    output sweep_dc, dc_count,
`endif
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_x, sweep_start,
    output out_valid, out_y, busy, sweep_valid, sweep_x, sweep_y, done,
           ones_count
  );
endinterface

// File: rtl/minterm_lut_sweep.sv
// minterm_lut_sweep: programmable N-input sum-of-minterms evaluator with a
// registered single-evaluation path and an exhaustive sweep engine that
// streams every input vector's result and counts true minterms.
// Optional don't-care support is enabled by defining MINTERM_LUT_DC_EN.
module minterm_lut_sweep #(
  parameter int                N         = 4,
  parameter logic [(1<<N)-1:0] INIT_MASK = 16'h001E
) (
  input logic             clk,
  input logic             rst_n,
  minterm_lut_sweep_if.slave bus
);

  localparam int M = 1 << N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state_q,       state_d;
  logic [M-1:0] mask_q,        mask_d;
  logic [N-1:0] idx_q,         idx_d;
  logic         out_valid_q,   out_valid_d;
  logic         out_y_q,       out_y_d;
  logic         sweep_valid_q, sweep_valid_d;
  logic [N-1:0] sweep_x_q,     sweep_x_d;
  logic         sweep_y_q,     sweep_y_d;
  logic         done_q,        done_d;
  logic [N:0]   ones_count_q,  ones_count_d;
`ifdef MINTERM_LUT_DC_EN
  logic [M-1:0] dc_q,          dc_d;
  logic         sweep_dc_q,    sweep_dc_d;
  logic [N:0]   dc_count_q,    dc_count_d;
  logic         sweep_dc_bit;
`endif

  logic eval_bit;
  logic sweep_bit;

  // Function value for the requested vector and for the current sweep index
  always_comb begin
`ifdef MINTERM_LUT_DC_EN
    eval_bit     = mask_q[bus.in_x] & ~dc_q[bus.in_x];
    sweep_bit    = mask_q[idx_q] & ~dc_q[idx_q];
    sweep_dc_bit = dc_q[idx_q];
`else
    eval_bit     = mask_q[bus.in_x];
    sweep_bit    = mask_q[idx_q];
`endif
  end

  // Next-state logic: IDLE services evaluations/writes/start, SWEEP streams
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    out_valid_d   = 1'b0;
    out_y_d       = out_y_q;
    sweep_valid_d = 1'b0;
    sweep_x_d     = sweep_x_q;
    sweep_y_d     = sweep_y_q;
    done_d        = 1'b0;
    ones_count_d  = ones_count_q;
`ifdef MINTERM_LUT_DC_EN
    dc_d          = dc_q;
    sweep_dc_d    = sweep_dc_q;
    dc_count_d    = dc_count_q;
`endif
    case (state_q)
      S_IDLE: begin
        // evaluation reads the pre-write mask, so a same-cycle write to the
        // same address returns the old bit
        if (bus.in_valid) begin
          out_valid_d = 1'b1;
          out_y_d     = eval_bit;
        end
        if (bus.cfg_we) begin
          mask_d[bus.cfg_addr] = bus.cfg_data;
`ifdef MINTERM_LUT_DC_EN
          dc_d[bus.cfg_addr]   = bus.cfg_dc;
`endif
        end
        if (bus.sweep_start) begin
          state_d      = S_SWEEP;
          idx_d        = '0;
          ones_count_d = '0;
`ifdef MINTERM_LUT_DC_EN
          dc_count_d   = '0;
`endif
        end
      end
      S_SWEEP: begin
        sweep_valid_d = 1'b1;
        sweep_x_d     = idx_q;
        sweep_y_d     = sweep_bit;
        ones_count_d  = ones_count_q + {{N{1'b0}}, sweep_bit};
`ifdef MINTERM_LUT_DC_EN
        sweep_dc_d    = sweep_dc_bit;
        dc_count_d    = dc_count_q + {{N{1'b0}}, sweep_dc_bit};
`endif
        idx_d         = idx_q + N'(1);
        if (idx_q == '1) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared (mask back to INIT_MASK)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mask_q        <= INIT_MASK;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_y_q       <= 1'b0;
      sweep_valid_q <= 1'b0;
      sweep_x_q     <= '0;
      sweep_y_q     <= 1'b0;
      done_q        <= 1'b0;
      ones_count_q  <= '0;
`ifdef MINTERM_LUT_DC_EN
      dc_q          <= '0;
      sweep_dc_q    <= 1'b0;
      dc_count_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      sweep_valid_q <= sweep_valid_d;
      sweep_x_q     <= sweep_x_d;
      sweep_y_q     <= sweep_y_d;
      done_q        <= done_d;
      ones_count_q  <= ones_count_d;
`ifdef MINTERM_LUT_DC_EN
      dc_q          <= dc_d;
      sweep_dc_q    <= sweep_dc_d;
      dc_count_q    <= dc_count_d;
`endif
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_y       = out_y_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sweep_valid = sweep_valid_q;
  assign bus.sweep_x     = sweep_x_q;
  assign bus.sweep_y     = sweep_y_q;
  assign bus.done        = done_q;
  assign bus.ones_count  = ones_count_q;
`ifdef MINTERM_LUT_DC_EN
  assign bus.sweep_dc    = sweep_dc_q;
  assign bus.dc_count    = dc_count_q;
`endif

endmodule

// File: tb/tb_minterm_lut_sweep.sv
// Self-checking bench for minterm_lut_sweep (default build, N=4).
module tb_minterm_lut_sweep;
  localparam int N   = 4;
  localparam int M   = 1 << N;
  localparam int BIG = 1000000;
  localparam logic [15:0] INIT = 16'h001E;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minterm_lut_sweep_if #(.N(N)) bus ();

  minterm_lut_sweep #(.N(N), .INIT_MASK(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the mask as a plain array, and the sweep described by
  // the distance d (in edges) from the edge that accepted sweep_start.
  bit           m_mask[M];
  int           cyc, st, d;
  bit           started;
  logic         e_ov, e_oy, e_sy;
  logic [N-1:0] e_sx;
  int           e_ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) m_mask[i] = INIT[i];
      cyc = 0; st = 0; started = 0; d = BIG;
      e_ov = 0; e_oy = 0; e_sx = '0; e_sy = 0; e_ones = 0;
    end else begin
      cyc++;
      d = started ? cyc - st : BIG;
      if (d >= M + 2) begin
        e_ov = bus.in_valid;
        if (bus.in_valid) e_oy = m_mask[bus.in_x];
        if (bus.cfg_we) m_mask[bus.cfg_addr] = bus.cfg_data;
        if (bus.sweep_start) begin
          started = 1; st = cyc; d = 0;
        end
      end else begin
        e_ov = 0;
      end
      if (d >= 1 && d <= M) begin
        e_sx = N'(d - 1);
        e_sy = m_mask[d - 1];
      end
      if (d <= M) begin
        e_ones = 0;
        for (int i = 0; i < d; i++) e_ones += int'(m_mask[i]);
      end
    end
    #1;
    chk("out_valid",   bus.out_valid,   e_ov);
    chk("out_y",       bus.out_y,       e_oy);
    chk("sweep_valid", bus.sweep_valid, (d >= 1 && d <= M));
    chk("sweep_x",     bus.sweep_x,     e_sx);
    chk("sweep_y",     bus.sweep_y,     e_sy);
    chk("busy",        bus.busy,        (d <= M));
    chk("done",        bus.done,        (d == M + 1));
    chk("ones_count",  32'(bus.ones_count), e_ones);
  end

  task automatic clear_inputs();
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = 0;
    bus.in_valid = 0; bus.in_x = '0; bus.sweep_start = 0;
  endtask

  task automatic eval_lit(input int x, input logic exp, input string nm);
    @(negedge clk);
    bus.in_valid = 1; bus.in_x = N'(x);
    @(posedge clk); #2;
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk(nm, bus.out_y, exp);
    bus.in_valid = 0;
  endtask

  task automatic write_bit(input int a, input logic v);
    @(negedge clk);
    bus.cfg_we = 1; bus.cfg_addr = N'(a); bus.cfg_data = v;
    @(posedge clk); #2;
    bus.cfg_we = 0;
  endtask

  task automatic run_sweep(input string nm, input int exp_ones);
    bit seen;
    int n;
    seen = 0; n = 0;
    @(negedge clk); bus.sweep_start = 1;
    @(negedge clk); bus.sweep_start = 0;
    while (!seen && n < 4 * M) begin
      @(posedge clk); #2;
      n++;
      if (bus.done) seen = 1;
    end
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_done_latency"}, n, M + 1);
    chk({nm, "_ones"}, 32'(bus.ones_count), exp_ones);
    chk({nm, "_busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dones, ovs;
    bit found;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ones", 32'(bus.ones_count), 0);
    rst_n = 1;

    // back-to-back evaluations of every vector
    for (int x = 0; x < M; x++) begin
      @(negedge clk);
      bus.in_valid = 1; bus.in_x = N'(x);
      @(posedge clk); #2;
      chk("eval_init", bus.out_y, (x >= 1 && x <= 4));
    end
    @(negedge clk); clear_inputs();

    run_sweep("sweep_init", 4);

    write_bit(15, 1);
    write_bit(1, 0);
    run_sweep("sweep_mod", 4);
    eval_lit(15, 1'b1, "eval15");
    eval_lit(1, 1'b0, "eval1");

    // same-cycle write and evaluation of address 2
    @(negedge clk);
    bus.cfg_we = 1; bus.cfg_addr = 4'd2; bus.cfg_data = 0;
    bus.in_valid = 1; bus.in_x = 4'd2;
    @(posedge clk); #2;
    chk("same_cycle_old", bus.out_y, 1'b1);
    bus.cfg_we = 0; bus.in_valid = 0;
    eval_lit(2, 1'b0, "repeat_new");

    write_bit(2, 1);

    // requests during a sweep are ignored
    dones = 0; ovs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i == 0) bus.sweep_start = 1;
      if (i >= 3 && i <= 6) begin
        bus.cfg_we = 1; bus.cfg_addr = 4'd0; bus.cfg_data = 1;
        bus.in_valid = 1; bus.in_x = 4'd3; bus.sweep_start = 1;
      end
      @(posedge clk); #2;
      if (bus.done) dones++;
      if (bus.out_valid) ovs++;
    end
    @(negedge clk); clear_inputs();
    chk("busy_done_pulses", dones, 1);
    chk("busy_out_valid", ovs, 0);
    chk("busy_ones", 32'(bus.ones_count), 4);
    eval_lit(0, 1'b0, "busy_write_ignored");

    // reset in mid-sweep
    @(negedge clk); bus.sweep_start = 1;
    @(negedge clk); bus.sweep_start = 0;
    found = 0;
    for (int i = 0; i < 3 * M && !found; i++) begin
      @(posedge clk); #2;
      if (bus.sweep_valid && bus.sweep_x == 4'd7) found = 1;
    end
    chk("reach_x7", found, 1'b1);
    rst_n = 0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_sweep_valid", bus.sweep_valid, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_ones", 32'(bus.ones_count), 0);
    @(negedge clk); rst_n = 1;
    eval_lit(4, 1'b1, "post_reset4");
    eval_lit(15, 1'b0, "post_reset15");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.cfg_we      = ($urandom_range(0, 3) == 0);
      bus.cfg_addr    = N'($urandom_range(0, M - 1));
      bus.cfg_data    = 1'($urandom_range(0, 1));
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.in_x        = N'($urandom_range(0, M - 1));
      bus.sweep_start = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk); clear_inputs();
    repeat (2 * M + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minterm_lut_sweep.md
Name: minterm_lut_sweep

Overview:
- Parametrised, programmable N-input sum-of-minterms function evaluator with a registered output and a built-in exhaustive sweep engine.
- Holds a 2^N-bit minterm mask: bit i = 1 means the function is true for input vector i.
- Serves single evaluations on request, or walks all 2^N input vectors and streams the results while counting true minterms.
- Successor to the fixed 4-input gate-level minterm function; reset mask reproduces Σm(1,2,3,4).

Parameters:
- N, 4, number of function inputs; legal range 1..8.
- INIT_MASK, 16'h001E, minterm mask loaded on reset; width 2^N (default = minterms 1,2,3,4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_we  in  1  mask write strobe.
- cfg_addr  in  N  minterm index to write.
- cfg_data  in  1  mask bit value.
- in_valid  in  1  single-evaluation request.
- in_x  in  N  input vector; MSB = first variable (A).
- out_valid  out  1  single-evaluation result valid.
- out_y  out  1  single-evaluation result.
- sweep_start  in  1  start exhaustive sweep.
- busy  out  1  sweep in progress.
- sweep_valid  out  1  streamed sweep result valid.
- sweep_x  out  N  vector being reported.
- sweep_y  out  1  mask[sweep_x].
- done  out  1  one-cycle sweep-complete pulse.
- ones_count  out  N+1  count of true minterms from the latest sweep.

Behaviour:
- Reset (async, rst_n=0): mask=INIT_MASK; state IDLE; all outputs 0; sweep index 0.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP: sweep_start=1 at an edge. At that edge busy=1, index=0, ones_count=0.
  - SWEEP: one vector per cycle. At each edge: sweep_valid=1, sweep_x=index, sweep_y=mask[index], ones_count += mask[index], index += 1.
  - SWEEP → DONE: on the edge that reports index 2^N−1. Index wraps to 0; no overflow into ones_count width.
  - DONE → IDLE: at the next edge. done=1 for exactly that cycle, busy=0, sweep_valid=0. ones_count then holds the final value until the next sweep start.
- Timing: with sweep_start sampled at edge k, sweep_valid is high after edges k+1 .. k+2^N, and done is high after edge k+2^N+1.
- Single evaluation:
  - Serviced in IDLE only; latency 1 cycle.
  - in_valid at edge k → out_valid=1, out_y=mask[in_x] after edge k; otherwise out_valid=0.
  - out_y holds its last value when out_valid=0.
- Mask write:
  - Honoured in IDLE only; takes effect at the edge.
  - An evaluation of the same address in the same cycle returns the OLD bit.
- While busy or in DONE:
  - cfg_we is ignored; the mask is frozen for the whole sweep.
  - in_valid is ignored (out_valid=0).
  - sweep_start is ignored.
- Simultaneous sweep_start and in_valid in IDLE: both are accepted; the evaluation result appears with latency 1.
- Reset mid-sweep: immediate abort; all state and outputs return to reset values, including the mask.

Optional Feature:
- Macro: MINTERM_LUT_DC_EN (don't-care support).
- Defined:
  - Adds a second 2^N-bit dc mask (reset value 0) and input port cfg_dc (1 bit), written alongside cfg_data.
  - Adds outputs sweep_dc (1 bit) and dc_count (N+1 bits).
  - For a vector with its dc bit set: out_y=0 and sweep_y=0; sweep_dc=1 on that report.
  - ones_count excludes dc minterms; dc_count counts them.
- Undefined: no dc storage; cfg_dc, sweep_dc and dc_count ports do not exist.

Test Plan:
- After reset, evaluate in_x=0..15 back-to-back → out_y=1 exactly for x=1,2,3,4; each result arrives 1 cycle after its request.
- Pulse sweep_start at edge k → sweep_valid after edges k+1..k+16 with sweep_x=0..15 and sweep_y=0,1,1,1,1,0,…; done pulse after edge k+17; ones_count=4; busy low after done.
- Write addr 15 data 1 and addr 1 data 0, then sweep → ones_count=4; in_x=15 → out_y=1; in_x=1 → out_y=0.
- Same cycle: cfg_we to addr 2 with data 0, plus in_valid with in_x=2 → out_y=1; a repeat evaluation one cycle later → out_y=0.
- During a sweep, issue cfg_we (addr 0, data 1), in_valid, and a second sweep_start → all ignored; ones_count=4; no out_valid; exactly one done pulse.
- Assert rst_n=0 while sweep_x=7 → busy, sweep_valid, done and ones_count read 0 immediately; mask back to 16'h001E (verify in_x=4 → out_y=1 after release).
